// File: rtl/tmr_scrub_regfile_if.sv
// Bus bundle for the triplicated register file: user read/write, fault
// injection and scrub status signals. Clock and reset stay outside.
interface tmr_scrub_regfile_if #(
    parameter int N  = 32,
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic [2:0]    rd_error;
    logic          fault_en;
    logic [1:0]    fault_replica;
    logic [AW-1:0] fault_addr;
    logic [N-1:0]  fault_mask;
    logic          scrub_en;
    logic          scrub_busy;
    logic          uncorrectable;
    logic [15:0]   corrected_count;
    logic [15:0]   uncorrectable_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output fault_en, fault_replica, fault_addr, fault_mask, scrub_en,
        input  rd_data, rd_valid, rd_error,
        input  scrub_busy, uncorrectable, corrected_count, uncorrectable_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  fault_en, fault_replica, fault_addr, fault_mask, scrub_en,
        output rd_data, rd_valid, rd_error,
        output scrub_busy, uncorrectable, corrected_count, uncorrectable_count
    );
endinterface

// File: rtl/tmr_scrub_regfile.sv
// Triplicated register file with majority-voted reads and a background
// scrubber that repairs single-replica upsets and counts unrepairable words.
module tmr_scrub_regfile #(
    parameter int N              = 32,
    parameter int DEPTH          = 16,
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    tmr_scrub_regfile_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_FIX} state_t;

    // Returns {error[2:0], voted_value}.
    function automatic logic [N+2:0] vote3(input logic [N-1:0] r0, r1, r2);
        logic m01, m02, m12;
        m01 = (r0 == r1);
        m02 = (r0 == r2);
        m12 = (r1 == r2);
        return {~(m02 | m12), ~(m01 | m12), ~(m01 | m02), (m02 ? r0 : r1)};
    endfunction

    logic [N-1:0]  rd_word  [3];
    logic [N-1:0]  scr_word [3];

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] scr_addr_q;
    logic          scrub_busy_q;
    logic          cancel_q;
    logic [N-1:0]  scr_val_q;
    logic [2:0]    scr_err_q;
    logic          uncorr_q;
    logic [15:0]   corr_cnt_q, corr_cnt_d;
    logic [15:0]   unc_cnt_q, unc_cnt_d;
    logic [N-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [2:0]    rd_error_q, rd_error_d;

    logic [N+2:0]  rd_vote, scr_vote;
    logic          wr_hit_scr, fix_live, unc_hit;
    logic [2:0]    fix_we;

    assign rd_vote  = vote3(rd_word[0], rd_word[1], rd_word[2]);
    assign scr_vote = vote3(scr_word[0], scr_word[1], scr_word[2]);

    always_comb begin
        wr_hit_scr = bus.wr_en && (bus.wr_addr == scr_addr_q);
        // A user write to the word under scrub makes the latched vote stale.
        fix_live   = (state_q == S_FIX) && !cancel_q && !wr_hit_scr;
        fix_we     = 3'b000;
        if (fix_live && (scr_err_q == 3'b001 || scr_err_q == 3'b010 || scr_err_q == 3'b100))
            fix_we = scr_err_q;
        unc_hit    = fix_live && (scr_err_q == 3'b111);
        corr_cnt_d = corr_cnt_q;
        if (fix_we != 3'b000 && corr_cnt_q != 16'hFFFF)
            corr_cnt_d = corr_cnt_q + 16'd1;
        unc_cnt_d  = unc_cnt_q;
        if (unc_hit && unc_cnt_q != 16'hFFFF)
            unc_cnt_d = unc_cnt_q + 16'd1;
        rd_valid_d = bus.rd_en;
        rd_data_d  = bus.rd_en ? rd_vote[N-1:0] : rd_data_q;
        rd_error_d = bus.rd_en ? rd_vote[N+2:N] : 3'b000;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rep
            logic [N-1:0] mem_q [DEPTH];
            logic [N-1:0] mem_d [DEPTH];
            logic         inj_hit;

            assign inj_hit = bus.fault_en && (bus.fault_replica == 2'(gi));

            // Later assignments win: fix, then injection on top, then user write.
            always_comb begin
                mem_d = mem_q;
                if (fix_we[gi])
                    mem_d[scr_addr_q] = scr_val_q;
                if (inj_hit)
                    mem_d[bus.fault_addr] = mem_d[bus.fault_addr] ^ bus.fault_mask;
                if (bus.wr_en)
                    mem_d[bus.wr_addr] = bus.wr_data;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++)
                        mem_q[i] <= '0;
                end else begin
                    mem_q <= mem_d;
                end
            end

            assign rd_word[gi]  = mem_q[bus.rd_addr];
            assign scr_word[gi] = mem_q[scr_addr_q];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            scr_addr_q   <= '0;
            scrub_busy_q <= 1'b0;
            cancel_q     <= 1'b0;
            scr_val_q    <= '0;
            scr_err_q    <= 3'b000;
            uncorr_q     <= 1'b0;
            corr_cnt_q   <= '0;
            unc_cnt_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_error_q   <= 3'b000;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_error_q <= rd_error_d;
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
            uncorr_q   <= unc_hit;
            case (state_q)
                S_IDLE: begin
                    if (bus.scrub_en) begin
                        cnt_q   <= RELOAD;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.scrub_en) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q      <= S_READ;
                        scrub_busy_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_READ: begin
                    scr_val_q <= scr_vote[N-1:0];
                    scr_err_q <= scr_vote[N+2:N];
                    cancel_q  <= wr_hit_scr;
                    state_q   <= S_FIX;
                end
                default: begin
                    scr_addr_q   <= scr_addr_q + 1'b1;
                    scrub_busy_q <= 1'b0;
                    cancel_q     <= 1'b0;
                    cnt_q        <= RELOAD;
                    state_q      <= bus.scrub_en ? S_WAIT : S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data             = rd_data_q;
    assign bus.rd_valid            = rd_valid_q;
    assign bus.rd_error            = rd_error_q;
    assign bus.scrub_busy          = scrub_busy_q;
    assign bus.uncorrectable       = uncorr_q;
    assign bus.corrected_count     = corr_cnt_q;
    assign bus.uncorrectable_count = unc_cnt_q;
endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Directed bench for tmr_scrub_regfile: voted reads, fault injection,
// scrub repair/wrap, uncorrectable detection, collisions and reset abort.
module tb_tmr_scrub_regfile;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    tmr_scrub_regfile_if #(.N(32), .AW(4)) bus ();

    tmr_scrub_regfile #(.N(32), .DEPTH(16), .SCRUB_INTERVAL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_inject(input logic [1:0] r, input logic [3:0] a, input logic [31:0] m);
        bus.fault_en = 1'b1; bus.fault_replica = r; bus.fault_addr = a; bus.fault_mask = m;
        @(negedge clk);
        bus.fault_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a,
                           input logic [31:0] exp_d, input logic [2:0] exp_e);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, bus.rd_data, exp_d);
        chk({tag, "_err"}, 32'(bus.rd_error), 32'(exp_e));
        $display("read %s addr=%0d data=%h err=%b", tag, a, bus.rd_data, bus.rd_error);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!bus.scrub_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_seen"}, 32'(bus.scrub_busy), 32'd1);
    endtask

    initial begin
        int n;
        int reads;
        int pulses;
        logic prev_busy;

        reset = 1'b1;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_en = 0; bus.rd_addr = 0;
        bus.fault_en = 0; bus.fault_replica = 0; bus.fault_addr = 0; bus.fault_mask = 0;
        bus.scrub_en = 0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_rd_error", 32'(bus.rd_error), 32'd0);
        chk("rst_busy", 32'(bus.scrub_busy), 32'd0);
        chk("rst_uncorr", 32'(bus.uncorrectable), 32'd0);
        chk("rst_corr_cnt", 32'(bus.corrected_count), 32'd0);
        chk("rst_unc_cnt", 32'(bus.uncorrectable_count), 32'd0);

        // Basic write/read, latency and hold
        do_write(4'd3, 32'hDEADBEEF);
        do_read("rd3", 4'd3, 32'hDEADBEEF, 3'b000);
        @(negedge clk);
        chk("hold_valid", 32'(bus.rd_valid), 32'd0);
        chk("hold_data", bus.rd_data, 32'hDEADBEEF);
        do_read("rd5_unwritten", 4'd5, 32'h0, 3'b000);

        // Single-replica faults
        do_write(4'd2, 32'h12345678);
        do_inject(2'd2, 4'd2, 32'h000000FF);
        do_read("inj_r2", 4'd2, 32'h12345678, 3'b100);
        do_write(4'd2, 32'h12345678);
        do_inject(2'd0, 4'd2, 32'h000000FF);
        do_read("inj_r0", 4'd2, 32'h12345678, 3'b001);

        // Read-before-write, then replica 3 injection ignored
        bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h0BADF00D;
        @(negedge clk);
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        chk("rbw_data", bus.rd_data, 32'hDEADBEEF);
        do_inject(2'd3, 4'd3, 32'h0000FFFF);
        do_read("inj_r3_ignored", 4'd3, 32'h0BADF00D, 3'b000);

        // Write beats same-address injection; different-address injection proceeds
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 32'hCAFEF00D;
        bus.fault_en = 1'b1; bus.fault_replica = 2'd1; bus.fault_addr = 4'd1; bus.fault_mask = 32'hFFFF;
        @(negedge clk);
        bus.wr_addr = 4'd4; bus.wr_data = 32'h11111111;
        bus.fault_replica = 2'd0; bus.fault_addr = 4'd6; bus.fault_mask = 32'h1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.fault_en = 1'b0;
        do_read("wr_beats_inj", 4'd1, 32'hCAFEF00D, 3'b000);
        do_read("wr_other", 4'd4, 32'h11111111, 3'b000);
        do_read("inj_other", 4'd6, 32'h0, 3'b001);

        // Scrub repair of replica 1 at addr 0, then wrap back to addr 0
        do_reset();
        do_inject(2'd1, 4'd0, 32'h00000F0F);
        bus.scrub_en = 1'b1;
        n = 0;
        while (bus.corrected_count != 16'd1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scrub_fix1_cnt", 32'(bus.corrected_count), 32'd1);
        chk("scrub_fix1_unc", 32'(bus.uncorrectable_count), 32'd0);
        do_read("scrub_fixed", 4'd0, 32'h0, 3'b000);
        do_inject(2'd1, 4'd0, 32'h00000F0F);
        reads = 0; prev_busy = bus.scrub_busy; n = 0;
        while (bus.corrected_count != 16'd2 && n < 300) begin
            @(negedge clk);
            if (bus.scrub_busy && !prev_busy) reads++;
            prev_busy = bus.scrub_busy;
            n++;
        end
        chk("scrub_wrap_cnt", 32'(bus.corrected_count), 32'd2);
        chk("scrub_wrap_steps", 32'(reads), 32'd16);
        $display("scrub wrap: steps=%0d corrected=%0d", reads, bus.corrected_count);
        bus.scrub_en = 1'b0;

        // Uncorrectable word at addr 7
        do_reset();
        do_inject(2'd0, 4'd7, 32'h1);
        do_inject(2'd2, 4'd7, 32'h2);
        do_read("unc_pre", 4'd7, 32'h0, 3'b111);
        bus.scrub_en = 1'b1;
        pulses = 0; n = 0;
        while (bus.uncorrectable_count != 16'd1 && n < 200) begin
            @(negedge clk);
            if (bus.uncorrectable) pulses++;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.uncorrectable) pulses++;
        end
        bus.scrub_en = 1'b0;
        chk("unc_cnt", 32'(bus.uncorrectable_count), 32'd1);
        chk("unc_pulses", 32'(pulses), 32'd1);
        chk("unc_no_corr", 32'(bus.corrected_count), 32'd0);
        do_read("unc_post", 4'd7, 32'h0, 3'b111);

        // User write during READ cancels the fix
        do_reset();
        do_inject(2'd1, 4'd0, 32'h000000FF);
        bus.scrub_en = 1'b1;
        wait_busy("coll");
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("coll_fix_busy", 32'(bus.scrub_busy), 32'd1);
        @(negedge clk);
        bus.scrub_en = 1'b0;
        chk("coll_done_busy", 32'(bus.scrub_busy), 32'd0);
        chk("coll_corr_cnt", 32'(bus.corrected_count), 32'd0);
        chk("coll_unc_cnt", 32'(bus.uncorrectable_count), 32'd0);
        do_read("coll_rd", 4'd0, 32'hA5A5A5A5, 3'b000);

        // Reset during FIX
        do_reset();
        do_write(4'd2, 32'h00000055);
        do_inject(2'd1, 4'd0, 32'h000000F0);
        do_read("pre_rst", 4'd2, 32'h00000055, 3'b000);
        bus.scrub_en = 1'b1;
        wait_busy("rstfix");
        @(negedge clk);
        chk("rstfix_in_fix", 32'(bus.scrub_busy), 32'd1);
        reset = 1'b1;
        bus.scrub_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rstfix_rd_data", bus.rd_data, 32'd0);
        chk("rstfix_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rstfix_busy", 32'(bus.scrub_busy), 32'd0);
        chk("rstfix_uncorr", 32'(bus.uncorrectable), 32'd0);
        chk("rstfix_corr_cnt", 32'(bus.corrected_count), 32'd0);
        chk("rstfix_unc_cnt", 32'(bus.uncorrectable_count), 32'd0);
        do_read("rstfix_cleared", 4'd2, 32'h0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tmr_scrub_regfile.md
Name: tmr_scrub_regfile

Overview:
- Triplicated register file: every write fans out to three replicas; every read is majority-voted, with a per-replica error flag.
- A background scrub FSM walks the addresses, votes each word, and rewrites a single disagreeing replica with the majority value. It counts corrected and uncorrectable words.
- Used for CPU-adjacent state that must survive single-replica upsets. Includes a fault-injection port for verification.

Parameters:
- N, 32, word width in bits (1-32).
- DEPTH, 16, number of words; power of two, 2-256.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- SCRUB_INTERVAL, 256, idle cycles between scrub steps (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- wr_en  in  1  write all three replicas at wr_addr.
- wr_addr  in  AW  write address.
- wr_data  in  N  write data.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  N  voted read data.
- rd_valid  out  1  rd_data/rd_error valid, one-cycle pulse.
- rd_error  out  3  bit i set = replica i disagrees with both others.
- fault_en  in  1  inject fault.
- fault_replica  in  2  target replica 0-2; value 3 ignored.
- fault_addr  in  AW  injection address.
- fault_mask  in  N  bits XORed into the target replica.
- scrub_en  in  1  enable background scrubbing.
- scrub_busy  out  1  high during scrub READ/FIX.
- uncorrectable  out  1  one-cycle pulse: scrub found all three replicas different.
- corrected_count  out  16  saturating count of scrub repairs.
- uncorrectable_count  out  16  saturating count of uncorrectable scrub words.

Behaviour:
- Reset (synchronous, active-high):
  - All replica words are cleared to 0.
  - rd_data=0, rd_valid=0, rd_error=0, scrub_busy=0, uncorrectable=0, both counters=0.
  - Scrub address=0, FSM=IDLE, interval counter=0.
  - Reset mid-scrub aborts the step with no write-back.
- Vote (replicas R0, R1, R2):
  - Pairwise equality m01, m02, m12.
  - Output value = R0 if m02, else R1.
  - error[0]=~(m01|m02); error[1]=~(m01|m12); error[2]=~(m02|m12).
  - All three different: output R1, error=3'b111.
  - All equal: error=0.
- Read:
  - Latency 1: rd_en at cycle t gives rd_valid, rd_data and rd_error at t+1.
  - Read-before-write: a same-cycle write or injection at rd_addr is not visible.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back reads are supported every cycle.
- Write: wr_en updates R0, R1 and R2 at wr_addr in the same cycle.
- Fault injection:
  - fault_en XORs fault_mask into replica fault_replica at fault_addr.
  - Injection is accepted in any state.
- Same-address, same-cycle priority: reset > write > injection > scrub fix.
  - Write beats injection entirely.
  - Injection at a different address proceeds alongside the write.
- Scrub FSM:
  - IDLE: if scrub_en, load interval counter with SCRUB_INTERVAL-1 and go to WAIT.
  - WAIT: decrement the counter. At 0 go to READ. If scrub_en drops, go to IDLE immediately; the address is kept.
  - READ (1 cycle): latch the three replicas at the scrub address and their vote; scrub_busy=1.
  - FIX (1 cycle, scrub_busy=1):
    - Exactly one error bit set: rewrite that replica with the voted value and increment corrected_count.
    - Error=3'b111: pulse uncorrectable, increment uncorrectable_count, no write.
    - Error=0: no action.
    - Then increment the scrub address modulo DEPTH (DEPTH-1 wraps to 0) and return to WAIT, or to IDLE if scrub_en=0.
  - READ and FIX always complete once entered, even if scrub_en drops.
- Scrub/user collision: a user write to the scrub address in READ or FIX cancels the fix. No write-back and no counter change; the address still advances.
- An injection at the scrub address during FIX is applied after the fix, so the injected value remains.
- Counters saturate at 16'hFFFF and clear only on reset.
- Reads are never stalled by scrubbing; reads use a separate read path from the scrub latch.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 3, then read addr 3 -> rd_valid at t+1, rd_data=0xDEADBEEF, rd_error=000; read unwritten addr 5 -> 0x00000000.
- Write 0x12345678 to addr 2; inject mask 0x000000FF into replica 2 -> read gives 0x12345678, rd_error=100. Repeat for replica 0 -> rd_error=001.
- SCRUB_INTERVAL=4, scrub_en=1, single fault in replica 1 at addr 0 -> FIX rewrites it, corrected_count=1, later read error=000. Scrub address wraps 15->0 after 16 steps.
- Inject different masks into replicas 0 and 2 at addr 7 -> read error=111 with R1 data; scrub pulses uncorrectable once, uncorrectable_count=1, no repair.
- With a fault pending at the scrub address, issue a user write of 0xA5A5A5A5 in the READ cycle -> no fix, counters unchanged, read returns 0xA5A5A5A5, error=000.
- Same cycle: wr_en and fault_en at addr 1 -> write wins, error=000. Separately, assert reset during FIX -> no write-back, all outputs and counters zero next cycle.
